facto_bus_sequencer: RTL and testbench
======================================

Name: facto_bus_sequencer

Overview:
- Bus master that runs one factorial job end to end over the shared single-master bus.
- Accepts a start pulse with an operand N and programs the factorial core over the bus.
- Waits for the core's interrupt, then reads the 128-bit result and stores both halves into RAM at a caller-given address.
- Finally clears the core.
- Sits on the master side of the bus, in place of the external master, so software and test benches need one pulse per job.

Parameters:
- FACTO_BASE, 16'h7000: base address of the factorial core register window.
- OFS_START, 16'h0000: opstart register offset; write 1 starts the core.
- OFS_CLEAR, 16'h0008: opclear register offset; write 1 clears the core.
- OFS_DONE, 16'h0010: opdone register offset; read bit0 = done.
- OFS_INTEN, 16'h0018: interrupt-enable register offset.
- OFS_OPERAND, 16'h0020: operand register offset.
- OFS_RES_H, 16'h0028: result high 64 bits.
- OFS_RES_L, 16'h0030: result low 64 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request; sampled only in IDLE
- operand  in  64  N; captured on accepted start
- dst_addr  in  16  RAM byte address for result_h; result_l goes to dst_addr+8; captured on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when job completes
- result_h  out  64  last result high word, held until next job
- result_l  out  64  last result low word, held until next job
- m_req  out  1  bus request
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  16  bus address
- m_dout  out  64  write data
- m_grant  in  1  bus grant
- m_din  in  64  read data
- interrupt  in  1  factorial core completion interrupt, level

Behaviour:
- Reset values: all outputs 0; state IDLE; captured operand and dst_addr 0.
- Async reset mid-job aborts immediately to IDLE. The core is not cleared; the next job still issues CLEAR first.
- Bus rule: a write or read address is issued only in a cycle with m_req=1 and m_grant=1.
- If m_grant is low, the FSM stalls with m_addr, m_wr and m_dout held, and m_req stays high.
- Read data is sampled from m_din in the cycle after the read address cycle (synchronous slaves).
- FSM order, one bus cycle per state unless noted:
  - IDLE: on start, capture inputs, busy=1 -> REQ.
  - REQ: m_req=1, wait for m_grant -> PRE_CLR.
  - PRE_CLR: write 1 to CLEAR.
  - W_INTEN: write 1 to INTEN.
  - W_OPND: write operand to OPERAND.
  - W_START: write 1 to START.
  - WAIT_IRQ: m_req=0, wait for interrupt=1.
  - REQ2: wait for grant.
  - R_H: read RES_H. R_H_CAP: capture result_h.
  - R_L: read RES_L. R_L_CAP: capture result_l.
  - W_RAM_H: write result_h to dst_addr.
  - W_RAM_L: write result_l to dst_addr+8 (16-bit wrap, no carry out).
  - W_CLR: write 1 to CLEAR.
  - FIN: m_req=0, busy=0, done=1 for one cycle -> IDLE.
- Register address = FACTO_BASE + offset, truncated to 16 bits.
- start while busy is ignored; no queueing.
- interrupt already high on entry to WAIT_IRQ, left over from an uncleared prior job, is impossible because PRE_CLR always runs first.
- Minimum job latency with grant always high: 13 bus cycles plus the core compute time.

Optional Feature:
- FACTO_POLL_EN defined:
  - WAIT_IRQ is replaced by a polling loop. The FSM keeps the bus and repeatedly reads DONE, 2 cycles per poll, until bit0=1.
  - The interrupt input is ignored.
  - W_INTEN writes 0 instead of 1.
- Not defined: interrupt-driven as described above, and m_req is released while waiting.

Test Plan:
- Reset, then start with operand=5, dst_addr=16'h0000, grant tied 1:
  - bus trace shows writes to 7008, 7018, 7020 (data 5), 7000;
  - after interrupt, reads of 7028 and 7030;
  - result_h=0 and result_l=120; RAM[0x0000]=0 and RAM[0x0008]=120; done pulses once.
- operand=0, dst_addr=16'h0010 -> result_l=1, result_h=0; RAM[0x0018]=1.
- operand=20 -> result_l=64'h21C3677C82B40000, result_h=0.
- Grant held low for 3 cycles during W_OPND:
  - m_addr stays 16'h7020 and m_dout stays the operand while m_req=1;
  - the sequence completes correctly after grant returns.
- Second start pulse while busy -> ignored; exactly one done pulse. Assert reset_n=0 during WAIT_IRQ -> all outputs 0 immediately; a new start afterwards completes normally.
- With FACTO_POLL_EN: operand=5 -> repeated reads of 16'h7010 until data bit0=1, then the same results as the first scenario; the interrupt input is ignored.

Source files
------------

// File: rtl/facto_bus_sequencer.sv
// ---------------------------------------------------------------------------
// facto_bus_sequencer
//
// Purpose:
//   Single-master bus sequencer that runs one factorial job per start pulse.
//   It clears and programs the factorial core over the bus, waits for the
//   core to finish, reads the 128-bit result (high then low word), stores
//   both words to RAM at dst_addr / dst_addr+8, and finally clears the core.
//
// Configuration macro:
//   FACTO_POLL_EN  - when defined, completion is detected by polling the
//                    core's DONE register while holding the bus. The
//                    interrupt input is then ignored and interrupts are
//                    disabled in the core (INTEN written with 0).
//                    When undefined, the sequencer releases the bus and
//                    waits for the level interrupt.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle job request, sampled only when idle
//   operand    in   [63:0] N, captured on accepted start
//   dst_addr   in   [15:0] RAM byte address for the high result word
//   busy       out  high from accepted start until done
//   done       out  one-cycle completion pulse
//   result_h   out  [63:0] last result high word
//   result_l   out  [63:0] last result low word
//   m_req      out  bus request
//   m_wr       out  1 = write, 0 = read
//   m_addr     out  [15:0] bus address
//   m_dout     out  [63:0] bus write data
//   m_grant    in   bus grant
//   m_din      in   [63:0] bus read data (valid the cycle after the read)
//   interrupt  in   core completion interrupt, level sensitive
// ---------------------------------------------------------------------------
module facto_bus_sequencer #(
    parameter logic [15:0] FACTO_BASE  = 16'h7000,
    parameter logic [15:0] OFS_START   = 16'h0000,
    parameter logic [15:0] OFS_CLEAR   = 16'h0008,
    parameter logic [15:0] OFS_DONE    = 16'h0010,
    parameter logic [15:0] OFS_INTEN   = 16'h0018,
    parameter logic [15:0] OFS_OPERAND = 16'h0020,
    parameter logic [15:0] OFS_RES_H   = 16'h0028,
    parameter logic [15:0] OFS_RES_L   = 16'h0030
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] operand,
    input  logic [15:0] dst_addr,
    output logic        busy,
    output logic        done,
    output logic [63:0] result_h,
    output logic [63:0] result_l,
    output logic        m_req,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic        m_grant,
    input  logic [63:0] m_din,
    input  logic        interrupt
);

    // Absolute register addresses; the sum wraps inside 16 bits.
    localparam logic [15:0] A_START   = 16'(FACTO_BASE + OFS_START);
    localparam logic [15:0] A_CLEAR   = 16'(FACTO_BASE + OFS_CLEAR);
    localparam logic [15:0] A_INTEN   = 16'(FACTO_BASE + OFS_INTEN);
    localparam logic [15:0] A_OPERAND = 16'(FACTO_BASE + OFS_OPERAND);
    localparam logic [15:0] A_RES_H   = 16'(FACTO_BASE + OFS_RES_H);
    localparam logic [15:0] A_RES_L   = 16'(FACTO_BASE + OFS_RES_L);

`ifdef FACTO_POLL_EN
    localparam logic [15:0] A_DONE    = 16'(FACTO_BASE + OFS_DONE);
    // Interrupt is not used when polling, so keep it masked in the core.
    localparam logic [63:0] INTEN_VAL = 64'd0;
`else
    localparam logic [63:0] INTEN_VAL = 64'd1;
`endif

    typedef enum logic [4:0] {
        S_IDLE,
        S_REQ,
        S_PRE_CLR,
        S_W_INTEN,
        S_W_OPND,
        S_W_START,
        S_WAIT_IRQ,
        S_POLL_RD,
        S_POLL_CAP,
        S_REQ2,
        S_R_H,
        S_R_H_CAP,
        S_R_L,
        S_R_L_CAP,
        S_W_RAM_H,
        S_W_RAM_L,
        S_W_CLR,
        S_FIN
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [63:0] r_res_h;
    logic [63:0] r_res_l;
    logic        r_req;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [63:0] r_dout;
    logic [63:0] r_opnd;
    logic [15:0] r_dst;

    assign busy     = r_busy;
    assign done     = r_done;
    assign result_h = r_res_h;
    assign result_l = r_res_l;
    assign m_req    = r_req;
    assign m_wr     = r_wr;
    assign m_addr   = r_addr;
    assign m_dout   = r_dout;

    // Bus outputs are registered: each state's transition loads the address,
    // direction and data of the NEXT bus cycle. A bus state only advances
    // when m_grant is high, so a denied cycle simply holds the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res_h <= 64'd0;
            r_res_l <= 64'd0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 16'd0;
            r_dout  <= 64'd0;
            r_opnd  <= 64'd0;
            r_dst   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opnd  <= operand;
                        r_dst   <= dst_addr;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_wr    <= 1'b0;
                        r_addr  <= 16'd0;
                        r_dout  <= 64'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (m_grant) begin
                        r_wr    <= 1'b1;
                        r_addr  <= A_CLEAR;
                        r_dout  <= 64'd1;
                        r_state <= S_PRE_CLR;
                    end
                end
                // Always clear first: a job aborted by reset may have left
                // the core with done/interrupt still asserted.
                S_PRE_CLR: begin
                    if (m_grant) begin
                        r_addr  <= A_INTEN;
                        r_dout  <= INTEN_VAL;
                        r_state <= S_W_INTEN;
                    end
                end
                S_W_INTEN: begin
                    if (m_grant) begin
                        r_addr  <= A_OPERAND;
                        r_dout  <= r_opnd;
                        r_state <= S_W_OPND;
                    end
                end
                S_W_OPND: begin
                    if (m_grant) begin
                        r_addr  <= A_START;
                        r_dout  <= 64'd1;
                        r_state <= S_W_START;
                    end
                end
`ifdef FACTO_POLL_EN
                // Keep the bus and alternate read / capture of DONE.
                S_W_START: begin
                    if (m_grant) begin
                        r_wr    <= 1'b0;
                        r_addr  <= A_DONE;
                        r_dout  <= 64'd0;
                        r_state <= S_POLL_RD;
                    end
                end
                S_POLL_RD: begin
                    if (m_grant) begin
                        r_state <= S_POLL_CAP;
                    end
                end
                S_POLL_CAP: begin
                    if (m_din[0]) begin
                        r_addr  <= A_RES_H;
                        r_state <= S_R_H;
                    end else begin
                        r_state <= S_POLL_RD;
                    end
                end
`else
                // Release the bus while the core computes.
                S_W_START: begin
                    if (m_grant) begin
                        r_req   <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= 16'd0;
                        r_dout  <= 64'd0;
                        r_state <= S_WAIT_IRQ;
                    end
                end
                S_WAIT_IRQ: begin
                    if (interrupt) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ2;
                    end
                end
                S_REQ2: begin
                    if (m_grant) begin
                        r_addr  <= A_RES_H;
                        r_state <= S_R_H;
                    end
                end
`endif
                S_R_H: begin
                    if (m_grant) begin
                        r_state <= S_R_H_CAP;
                    end
                end
                // Synchronous slave: read data is valid one cycle after
                // the address cycle, independent of grant.
                S_R_H_CAP: begin
                    r_res_h <= m_din;
                    r_addr  <= A_RES_L;
                    r_state <= S_R_L;
                end
                S_R_L: begin
                    if (m_grant) begin
                        r_state <= S_R_L_CAP;
                    end
                end
                S_R_L_CAP: begin
                    r_res_l <= m_din;
                    r_wr    <= 1'b1;
                    r_addr  <= r_dst;
                    r_dout  <= r_res_h;
                    r_state <= S_W_RAM_H;
                end
                S_W_RAM_H: begin
                    if (m_grant) begin
                        // 16-bit wrap intended: no carry beyond the bus width.
                        r_addr  <= r_dst + 16'd8;
                        r_dout  <= r_res_l;
                        r_state <= S_W_RAM_L;
                    end
                end
                S_W_RAM_L: begin
                    if (m_grant) begin
                        r_addr  <= A_CLEAR;
                        r_dout  <= 64'd1;
                        r_state <= S_W_CLR;
                    end
                end
                S_W_CLR: begin
                    if (m_grant) begin
                        r_req   <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= 16'd0;
                        r_dout  <= 64'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_wr    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_facto_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_facto_bus_sequencer
//
// Drives factorial jobs into facto_bus_sequencer, models the factorial core
// and a 64-bit RAM as bus slaves, and checks results through a scoreboard:
// each accepted start pushes the expected result/destination, and a monitor
// pops and compares on every done pulse. Honours FACTO_POLL_EN.
// ---------------------------------------------------------------------------
module tb_facto_bus_sequencer;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic        start    = 1'b0;
    logic [63:0] operand  = 64'd0;
    logic [15:0] dst_addr = 16'd0;
    logic        m_grant  = 1'b1;
    logic [63:0] m_din    = 64'd0;
    logic        busy, done, m_req, m_wr, interrupt;
    logic [63:0] result_h, result_l, m_dout;
    logic [15:0] m_addr;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    bit gnt_rand = 1'b0;
    int core_delay = 4;

`ifdef FACTO_POLL_EN
    localparam logic [63:0] EXP_INTEN = 64'd0;
`else
    localparam logic [63:0] EXP_INTEN = 64'd1;
`endif

    facto_bus_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .operand  (operand),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .result_h (result_h),
        .result_l (result_l),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_grant  (m_grant),
        .m_din    (m_din),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    function automatic logic [127:0] fact128(input logic [63:0] n);
        logic [127:0] f = 128'd1;
        for (int i = 2; i <= int'(n); i++) f = f * 128'(i);
        return f;
    endfunction

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'h7000) && (a < 16'h7040);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- core + RAM slave model ----------------
    logic [127:0] core_res   = 128'd0;
    logic [63:0]  core_opnd  = 64'd0;
    logic         core_done  = 1'b0;
    logic         core_inten = 1'b0;
    int           core_cnt   = 0;
    logic [63:0]  ram [0:65535];

    typedef struct packed { logic [15:0] a; logic [63:0] d; } wr_t;
    wr_t         wr_q[$];
    logic [15:0] rd_q[$];

`ifdef FACTO_POLL_EN
    assign interrupt = 1'b1;
`else
    assign interrupt = core_done & core_inten;
`endif

    always @(posedge clk) begin
        if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
        end
        if (m_req && m_grant) begin
            if (m_wr) begin
                wr_q.push_back({m_addr, m_dout});
                if (!in_win(m_addr)) ram[m_addr] <= m_dout;
                else if (m_addr == 16'h7000 && m_dout[0]) begin
                    core_res  <= fact128(core_opnd);
                    core_done <= 1'b0;
                    core_cnt  <= core_delay;
                end else if (m_addr == 16'h7008 && m_dout[0]) begin
                    core_done <= 1'b0;
                    core_cnt  <= 0;
                end else if (m_addr == 16'h7018) core_inten <= m_dout[0];
                else if (m_addr == 16'h7020) core_opnd <= m_dout;
            end else begin
                if (in_win(m_addr) && (rd_q.size() == 0 || rd_q[rd_q.size()-1] != m_addr))
                    rd_q.push_back(m_addr);
                case (m_addr)
                    16'h7010: m_din <= {63'd0, core_done};
                    16'h7028: m_din <= core_res[127:64];
                    16'h7030: m_din <= core_res[63:0];
                    default:  m_din <= in_win(m_addr) ? 64'd0 : ram[m_addr];
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (gnt_rand) m_grant = ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct packed { logic [63:0] h; logic [63:0] l; logic [15:0] dst; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done_pulse required=no_pulse");
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_result_h", result_h, mon_e.h);
                chk("sb_result_l", result_l, mon_e.l);
                chk("sb_ram_h", ram[mon_e.dst], mon_e.h);
                chk("sb_ram_l", ram[16'(mon_e.dst + 16'd8)], mon_e.l);
                chk("sb_busy_at_done", busy, 0);
            end
        end
    end

    // A denied write must hold address, data and request.
    logic        p_stall = 1'b0;
    logic [15:0] p_addr  = 16'd0;
    logic [63:0] p_dout  = 64'd0;
    always @(negedge clk) begin
        if (reset_n && p_stall) begin
            chk("hold_req", m_req, 1);
            chk("hold_wr", m_wr, 1);
            chk("hold_addr", m_addr, p_addr);
            chk("hold_dout", m_dout, p_dout);
        end
        p_stall = reset_n && m_req && m_wr && !m_grant;
        p_addr  = m_addr;
        p_dout  = m_dout;
    end

    // ---------------- stimulus tasks ----------------
    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result_h"}, result_h, 0);
        chk({tag, "_result_l"}, result_l, 0);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_m_wr"}, m_wr, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_dout"}, m_dout, 0);
    endtask

    task automatic issue_start(input logic [63:0] op, input logic [15:0] dst, input bit accept);
        exp_t         e;
        logic [127:0] f;
        @(posedge clk); #1;
        operand  = op;
        dst_addr = dst;
        start    = 1'b1;
        if (accept) begin
            f     = fact128(op);
            e.h   = f[127:64];
            e.l   = f[63:0];
            e.dst = dst;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d_cycles", budget);
        end
    endtask

    task automatic post_job(input logic [63:0] op, input logic [15:0] dst, input int d0);
        logic [127:0] f;
        logic [15:0]  wa[7];
        logic [63:0]  wd[7];
        logic [15:0]  ra[$];
        f  = fact128(op);
        wa = '{16'h7008, 16'h7018, 16'h7020, 16'h7000, dst, 16'(dst + 16'd8), 16'h7008};
        wd = '{64'd1, EXP_INTEN, op, 64'd1, f[127:64], f[63:0], 64'd1};
`ifdef FACTO_POLL_EN
        ra = {16'h7010, 16'h7028, 16'h7030};
`else
        ra = {16'h7028, 16'h7030};
`endif
        @(posedge clk); #1;
        chk("done_once", done_cnt - d0, 1);
        chk("done_one_cycle", done, 0);
        chk("wr_count", wr_q.size(), 7);
        for (int i = 0; i < 7 && i < wr_q.size(); i++) begin
            chk($sformatf("wr_addr_%0d", i), wr_q[i].a, wa[i]);
            chk($sformatf("wr_data_%0d", i), wr_q[i].d, wd[i]);
        end
        chk("rd_count", rd_q.size(), ra.size());
        for (int i = 0; i < ra.size() && i < rd_q.size(); i++)
            chk($sformatf("rd_addr_%0d", i), rd_q[i], ra[i]);
    endtask

    task automatic run_job(input logic [63:0] op, input logic [15:0] dst);
        int d0;
        d0 = done_cnt;
        wr_q.delete();
        rd_q.delete();
        issue_start(op, dst, 1'b1);
        wait_done(3000);
        post_job(op, dst, d0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  d0;
        bit  found;
        #1 reset_n = 1'b0;
        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic job, grant tied high.
        run_job(64'd5, 16'h0000);
        chk("t5_result_h", result_h, 0);
        chk("t5_result_l", result_l, 120);
        chk("t5_ram_0000", ram[16'h0000], 0);
        chk("t5_ram_0008", ram[16'h0008], 120);

        run_job(64'd0, 16'h0010);
        chk("t0_result_l", result_l, 1);
        chk("t0_result_h", result_h, 0);
        chk("t0_ram_0018", ram[16'h0018], 1);

        run_job(64'd20, 16'h0020);
        chk("t20_result_l", result_l, 64'h21C3677C82B40000);
        chk("t20_result_h", result_h, 0);

        // Destination wraps: low word lands at 0x0000.
        run_job(64'd3, 16'hFFF8);
        chk("wrap_ram_0000", ram[16'h0000], 6);

        // Grant withheld for 3 cycles while the operand write is pending.
        d0 = done_cnt;
        wr_q.delete();
        rd_q.delete();
        issue_start(64'd12, 16'h0500, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_req && m_wr && m_addr == 16'h7020) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("stall_reached_w_opnd", found, 1);
        m_grant = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_addr", m_addr, 16'h7020);
            chk("stall_dout", m_dout, 12);
            chk("stall_req", m_req, 1);
            @(posedge clk); #1;
        end
        m_grant = 1'b1;
        wait_done(3000);
        post_job(64'd12, 16'h0500, d0);

        // Second start while busy is ignored.
        d0 = done_cnt;
        wr_q.delete();
        rd_q.delete();
        issue_start(64'd6, 16'h0100, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        issue_start(64'd9, 16'h0200, 1'b0);
        wait_done(3000);
        post_job(64'd6, 16'h0100, d0);
        repeat (30) @(posedge clk);
        #1;
        chk("ignored_start_done_cnt", done_cnt - d0, 1);
        chk("ignored_start_result_l", result_l, 720);

        // Reset while the core is computing.
        core_delay = 30;
        wr_q.delete();
        rd_q.delete();
        issue_start(64'd7, 16'h0300, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (wr_q.size() >= 4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("core_started", found, 1);
        repeat (3) @(posedge clk);
        #1;
`ifndef FACTO_POLL_EN
        chk("wait_irq_m_req", m_req, 0);
`endif
        chk("midjob_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_zero("midjob_reset");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        core_delay = 5;
        run_job(64'd10, 16'h0400);
        chk("after_reset_result_l", result_l, 64'd3628800);

        // Randomized jobs with random grant and core latency.
        gnt_rand = 1'b1;
        for (int j = 0; j < 12; j++) begin
            core_delay = $urandom_range(1, 20);
            run_job(64'($urandom_range(0, 34)), {13'($urandom_range(0, 13'h0DFF)), 3'b000});
        end
        gnt_rand = 1'b0;
        m_grant  = 1'b1;

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
